// File: rtl/regfile_pkg.sv
// Shared constants and types for the 2-read/1-write MIPS-style register file.
// Optional write-through forwarding is selected with REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DEPTH  = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/regfile_if.sv
// Register-file access bus: two read ports, one write port and the written-status bitmap.
// The master drives addresses and write data; the register file (slave) returns data.
interface regfile_if
  import regfile_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = REG_DEPTH
) ();

    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [ADDR_W-1:0] WriteRegister;
    logic [WIDTH-1:0]  WriteData;
    logic              RegWrite;
    logic [WIDTH-1:0]  ReadData1;
    logic [WIDTH-1:0]  ReadData2;
    logic [DEPTH-1:0]  Written;

    // Write is a single-edge command: no valid/ready, RegWrite qualifies the write fields
    // on each rising Clk; reads are combinational and always accepted.
    modport master (
        output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
        input  ReadData1, ReadData2, Written
    );

    modport slave (
        input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite,
        output ReadData1, ReadData2, Written
    );

endinterface

// File: rtl/regfile_wdecoder.sv
// One-hot write-enable decoder gated by RegWrite; bit 0 is never enabled so
// register 0 stays hardwired to zero.
module regfile_wdecoder
  import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = REG_DEPTH
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DEPTH-1:0]  onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
        onehot[0] = 1'b0;
    end

endmodule

// File: rtl/regfile_2r1w.sv
// 32 x 32-bit register file, two combinational read ports, one clocked write port,
// asynchronous clear and written-status bitmap. Build with REGFILE_BYPASS_EN for forwarding.
module regfile_2r1w
  import regfile_pkg::*;
#(
    parameter int WIDTH  = REG_WIDTH,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = REG_DEPTH
) (
    input logic      Clk,
    input logic      Reset,
    regfile_if.slave bus
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] written;
    logic [DEPTH-1:0] wen;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    regfile_wdecoder #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_wdecoder (
        .en     (bus.RegWrite),
        .addr   (bus.WriteRegister),
        .onehot (wen)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            written <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wen[i]) begin
                    regs[i]    <= bus.WriteData;
                    written[i] <= 1'b1;
                end
            end
        end
    end

    // Address 0 is forced to zero here as well, independent of array contents.
    always_comb begin
        rd1 = (bus.ReadRegister1 == '0) ? '0 : regs[bus.ReadRegister1];
        rd2 = (bus.ReadRegister2 == '0) ? '0 : regs[bus.ReadRegister2];
`ifdef REGFILE_BYPASS_EN
        if (bus.RegWrite && (bus.WriteRegister != '0) &&
            (bus.ReadRegister1 == bus.WriteRegister)) begin
            rd1 = bus.WriteData;
        end
        if (bus.RegWrite && (bus.WriteRegister != '0) &&
            (bus.ReadRegister2 == bus.WriteRegister)) begin
            rd2 = bus.WriteData;
        end
`else
        rd1 = rd1;
        rd2 = rd2;
`endif
    end

    assign bus.ReadData1 = rd1;
    assign bus.ReadData2 = rd2;
    assign bus.Written   = written;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed self-checking bench for regfile_2r1w (both default and REGFILE_BYPASS_EN builds).
module tb_regfile_2r1w;
    import regfile_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    regfile_if #(.WIDTH(REG_WIDTH), .ADDR_W(REG_ADDR_W), .DEPTH(REG_DEPTH)) bus ();

    regfile_2r1w #(
        .WIDTH  (REG_WIDTH),
        .ADDR_W (REG_ADDR_W),
        .DEPTH  (REG_DEPTH)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input reg_addr_t addr, input reg_data_t data);
        @(negedge clk);
        bus.WriteRegister = addr;
        bus.WriteData     = data;
        bus.RegWrite      = 1'b1;
        @(posedge clk);
        #1;
        bus.RegWrite      = 1'b0;
    endtask

    task automatic read2(input reg_addr_t a1, input reg_addr_t a2);
        bus.ReadRegister1 = a1;
        bus.ReadRegister2 = a2;
        #1;
    endtask

    initial begin
        reg_data_t exp_byp;
        tests_run         = 0;
        tests_failed      = 0;
        rst               = 1'b1;
        bus.ReadRegister1 = '0;
        bus.ReadRegister2 = '0;
        bus.WriteRegister = '0;
        bus.WriteData     = '0;
        bus.RegWrite      = 1'b0;
        #12;
        rst = 1'b0;

        // Reset then idle: every address reads 0 on both ports
        for (int a = 0; a < 32; a++) begin
            read2(reg_addr_t'(a), reg_addr_t'(31 - a));
            check($sformatf("reset_rd1[%0d]", a), bus.ReadData1, 32'd0);
            check($sformatf("reset_rd2[%0d]", 31 - a), bus.ReadData2, 32'd0);
        end
        check("reset_written", bus.Written, 32'd0);

        // Basic write and overwrite of reg 2
        do_write(5'd2, 32'd42);
        read2(5'd2, 5'd2);
        check("w2_rd1", bus.ReadData1, 32'd42);
        check("w2_rd2", bus.ReadData2, 32'd42);
        check("w2_written", bus.Written, 32'h0000_0004);
        do_write(5'd2, 32'd15);
        read2(5'd2, 5'd2);
        check("w2b_rd1", bus.ReadData1, 32'd15);
        check("w2b_rd2", bus.ReadData2, 32'd15);

        // Writes to register 0 are discarded
        do_write(5'd0, 32'hDEAD_BEEF);
        read2(5'd0, 5'd0);
        check("r0_rd1", bus.ReadData1, 32'd0);
        check("r0_rd2", bus.ReadData2, 32'd0);
        check("r0_written", bus.Written, 32'h0000_0004);

        // RegWrite low: no state change
        @(negedge clk);
        bus.WriteRegister = 5'd5;
        bus.WriteData     = 32'd7;
        bus.RegWrite      = 1'b0;
        @(posedge clk);
        #1;
        read2(5'd5, 5'd2);
        check("noen_rd1", bus.ReadData1, 32'd0);
        check("noen_rd2", bus.ReadData2, 32'd15);
        check("noen_written", bus.Written, 32'h0000_0004);

        // Fill regs 1..31 with k+100 and read everything back on both ports
        for (int k = 1; k < 32; k++) begin
            do_write(reg_addr_t'(k), reg_data_t'(k + 100));
        end
        for (int k = 1; k < 32; k++) begin
            read2(reg_addr_t'(k), reg_addr_t'(32 - k));
            check($sformatf("fill_rd1[%0d]", k), bus.ReadData1, 32'(k + 100));
            check($sformatf("fill_rd2[%0d]", 32 - k), bus.ReadData2, 32'(132 - k));
        end
        check("fill_written", bus.Written, 32'hFFFF_FFFE);

        // Async reset between edges while a write is pending
        do_write(5'd3, 32'd99);
        read2(5'd3, 5'd3);
        check("pre_rst_rd1", bus.ReadData1, 32'd99);
        @(negedge clk);
        bus.WriteRegister = 5'd3;
        bus.WriteData     = 32'd55;
        bus.RegWrite      = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_rd1", bus.ReadData1, 32'd0);
        check("async_rst_rd2", bus.ReadData2, 32'd0);
        check("async_rst_written", bus.Written, 32'd0);
        @(posedge clk);
        #1;
        check("rst_edge_rd1", bus.ReadData1, 32'd0);
        read2(5'd7, 5'd3);
        check("rst_edge_rd_other", bus.ReadData1, 32'd0);
        check("rst_edge_written", bus.Written, 32'd0);
        @(negedge clk);
        bus.RegWrite = 1'b0;
        rst          = 1'b0;

        // Read during write: forwarded only in the bypass build
        do_write(5'd4, 32'd10);
        @(negedge clk);
        bus.WriteRegister = 5'd4;
        bus.WriteData     = 32'd20;
        bus.RegWrite      = 1'b1;
        read2(5'd4, 5'd0);
`ifdef REGFILE_BYPASS_EN
        exp_byp = 32'd20;
`else
        exp_byp = 32'd10;
`endif
        check("byp_pre_rd1", bus.ReadData1, exp_byp);
        check("byp_pre_rd2_zero", bus.ReadData2, 32'd0);
        @(posedge clk);
        #1;
        bus.RegWrite = 1'b0;
        check("byp_post_rd1", bus.ReadData1, 32'd20);
        check("byp_written", bus.Written, 32'h0000_0010);

        // Pending write to reg 0 never forwards
        @(negedge clk);
        bus.WriteRegister = 5'd0;
        bus.WriteData     = 32'h1234_5678;
        bus.RegWrite      = 1'b1;
        read2(5'd0, 5'd4);
        check("byp_r0_rd1", bus.ReadData1, 32'd0);
        check("byp_r0_rd2", bus.ReadData2, 32'd20);
        @(posedge clk);
        #1;
        bus.RegWrite = 1'b0;
        check("byp_r0_post", bus.ReadData1, 32'd0);
        check("byp_r0_written", bus.Written, 32'h0000_0010);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
